// File: rtl/sign_mag_add_bcd_pkg.sv
// Shared definitions for the sign-magnitude adder / BCD converter slice.
// Contents:
//   state_t     - FSM state encoding (IDLE, ADD, CONV, LOAD)
//   MAG_W       - operand magnitude width
//   SUM_W       - result magnitude width
//   N_DIGITS    - number of BCD digits produced
//   N_ITER      - number of double-dabble iterations
//   SHIFT_W     - width of the combined BCD/binary shift register
//   SIGN_NEG    - sign code shown on the display for a negative result
//   SIGN_POS    - sign code shown on the display for a non-negative result
//   dabble_adj  - add-3 correction applied to one BCD nibble
package sign_mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CONV = 2'd2,
    LOAD = 2'd3
  } state_t;

  localparam int MAG_W    = 7;
  localparam int SUM_W    = 8;
  localparam int N_DIGITS = 3;
  localparam int N_ITER   = 8;
  localparam int SHIFT_W  = N_DIGITS * 4 + SUM_W;

  localparam logic [3:0] SIGN_NEG = 4'b0001;
  localparam logic [3:0] SIGN_POS = 4'b0000;

  // A nibble of 5 or more would exceed 9 after the next doubling, so
  // pre-add 3 to make the shift carry into the next decimal digit.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/sign_mag_add_bcd_if.sv
// Request/result bundle between the operand source and the adder/BCD stage.
// Signals:
//   start       - request pulse, sampled only while the stage is idle
//   a, b        - sign-magnitude operands (bit 7 sign, bits 6:0 magnitude)
//   busy        - stage is working on a request
//   done        - one-cycle pulse when new digits are loaded
//   bcd0..bcd3  - ones digit, tens digit, sign code, hundreds digit
// Modports: master drives the request, slave is the adder/BCD stage.
interface sign_mag_add_bcd_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;

  modport master (
    output start, a, b,
    input  busy, done, bcd0, bcd1, bcd2, bcd3
  );

  modport slave (
    input  start, a, b,
    output busy, done, bcd0, bcd1, bcd2, bcd3
  );
endinterface

// File: rtl/sign_mag_add_bcd_add.sv
// Combinational 8+8 sign-magnitude adder.
// Ports:
//   a, b     in  8  operands (bit 7 sign, bits 6:0 magnitude)
//   sign_o   out 1  result sign, forced to 0 when the magnitude is 0
//   mag_o    out 8  result magnitude, 0..254
module sign_mag_add
  import sign_mag_pkg::*;
(
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             sign_o,
  output logic [SUM_W-1:0] mag_o
);

  logic             sa_s;
  logic             sb_s;
  logic [MAG_W-1:0] ma_s;
  logic [MAG_W-1:0] mb_s;
  logic [SUM_W-1:0] sum_s;
  logic             sign_raw_s;

  assign sa_s = a[7];
  assign sb_s = b[7];
  assign ma_s = a[MAG_W-1:0];
  assign mb_s = b[MAG_W-1:0];

  // Add magnitudes on equal signs, otherwise subtract smaller from larger.
  always_comb begin
    sum_s      = {SUM_W{1'b0}};
    sign_raw_s = 1'b0;
    if (sa_s == sb_s) begin
      sum_s      = {1'b0, ma_s} + {1'b0, mb_s};
      sign_raw_s = sa_s;
    end else if (ma_s > mb_s) begin
      sum_s      = {1'b0, ma_s - mb_s};
      sign_raw_s = sa_s;
    end else begin
      sum_s      = {1'b0, mb_s - ma_s};
      sign_raw_s = sb_s;
    end
  end

  // A zero result is never negative (covers -0 operands and x + -x).
  assign mag_o  = sum_s;
  assign sign_o = sign_raw_s & (sum_s != {SUM_W{1'b0}});

endmodule

// File: rtl/sign_mag_add_bcd.sv
// Sequential sign-magnitude adder with double-dabble binary-to-BCD
// conversion, feeding a 4-digit seven-segment display multiplexer.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of sign_mag_add_bcd_if (start/a/b in,
//          busy/done/bcd0..bcd3 out, all outputs registered)
// Outputs hold the previous result while a new one is being computed.
module sign_mag_add_bcd
  import sign_mag_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  sign_mag_add_bcd_if.slave bus
);

  localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);

  state_t             state_r;
  logic [7:0]         a_r;
  logic [7:0]         b_r;
  logic               sign_r;
  logic [SHIFT_W-1:0] shift_r;
  logic [2:0]         iter_r;
  logic               busy_r;
  logic               done_r;
  logic [3:0]         bcd0_r;
  logic [3:0]         bcd1_r;
  logic [3:0]         bcd2_r;
  logic [3:0]         bcd3_r;

  logic               sum_sign_s;
  logic [SUM_W-1:0]   sum_mag_s;
  logic [SHIFT_W-1:0] adj_s;
  logic [SHIFT_W-1:0] shifted_s;

  sign_mag_add u_add (
    .a      (a_r),
    .b      (b_r),
    .sign_o (sum_sign_s),
    .mag_o  (sum_mag_s)
  );

  // Add-3 correction on the three BCD nibbles, then shift left by one.
  always_comb begin
    adj_s         = shift_r;
    adj_s[19:16]  = dabble_adj(shift_r[19:16]);
    adj_s[15:12]  = dabble_adj(shift_r[15:12]);
    adj_s[11:8]   = dabble_adj(shift_r[11:8]);
    shifted_s     = {adj_s[SHIFT_W-2:0], 1'b0};
  end

  // Control FSM with operand, shift, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      sign_r  <= 1'b0;
      shift_r <= {SHIFT_W{1'b0}};
      iter_r  <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd0_r  <= 4'h0;
      bcd1_r  <= 4'h0;
      bcd2_r  <= 4'h0;
      bcd3_r  <= 4'h0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            busy_r  <= 1'b1;
            state_r <= ADD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ADD: begin
          shift_r <= {{(SHIFT_W - SUM_W){1'b0}}, sum_mag_s};
          sign_r  <= sum_sign_s;
          iter_r  <= 3'd0;
          state_r <= CONV;
        end
        CONV: begin
          shift_r <= shifted_s;
          if (iter_r == LAST_ITER) begin
            state_r <= LOAD;
          end else begin
            iter_r  <= iter_r + 3'd1;
          end
        end
        LOAD: begin
          bcd0_r  <= shift_r[11:8];
          bcd1_r  <= shift_r[15:12];
          bcd3_r  <= shift_r[19:16];
          // sign_r is already cleared for a zero magnitude by the adder.
          bcd2_r  <= sign_r ? SIGN_NEG : SIGN_POS;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bcd0 = bcd0_r;
  assign bus.bcd1 = bcd1_r;
  assign bus.bcd2 = bcd2_r;
  assign bus.bcd3 = bcd3_r;

endmodule

// File: tb/tb_sign_mag_add_bcd.sv
// Self-checking bench for sign_mag_add_bcd: table-driven vectors, random
// vectors against a decimal model, back-to-back start and mid-op reset.
module tb_sign_mag_add_bcd;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sign_mag_add_bcd_if bus();

  sign_mag_add_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected {bcd3, bcd2, bcd1, bcd0}
  logic [15:0] sb_q[$];
  logic [15:0] outs_s;
  assign outs_s = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int va;
    int vb;
    int s;
    int m;
    va = a[7] ? -int'({25'd0, a[6:0]}) : int'({25'd0, a[6:0]});
    vb = b[7] ? -int'({25'd0, b[6:0]}) : int'({25'd0, b[6:0]});
    s  = va + vb;
    m  = (s < 0) ? -s : s;
    return {4'(m / 100), (s < 0) ? 4'b0001 : 4'b0000, 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_done(input string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: done with empty scoreboard", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, " digits"}, {16'd0, outs_s}, {16'd0, e});
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input string name);
    logic [15:0] prev;
    int n;
    int stable;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    chk({name, " busy"}, {31'd0, bus.busy}, 32'd1);
    prev   = outs_s;
    n      = 0;
    stable = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      if (outs_s !== prev) stable = 0;
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, n, 32'd10);
    chk({name, " hold"}, stable, 32'd1);
    check_done(name);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({name, " busy_end"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;
    logic [7:0]  av;
    logic [7:0]  bv;
    int dones;

    vecs[0]  = '{8'h05, 8'h03, 16'h0008};
    vecs[1]  = '{8'h64, 8'h7F, 16'h2027};
    vecs[2]  = '{8'h14, 8'hAD, 16'h0125};
    vecs[3]  = '{8'h87, 8'h07, 16'h0000};
    vecs[4]  = '{8'h80, 8'h80, 16'h0000};
    vecs[5]  = '{8'h7F, 8'h7F, 16'h2054};
    vecs[6]  = '{8'hFF, 8'h7F, 16'h0000};
    vecs[7]  = '{8'h8A, 8'h05, 16'h0105};
    vecs[8]  = '{8'h09, 8'h01, 16'h0010};
    vecs[9]  = '{8'h63, 8'h00, 16'h0099};
    vecs[10] = '{8'h00, 8'h00, 16'h0000};
    vecs[11] = '{8'h85, 8'h8A, 16'h0115};

    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    #12;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset digits", {16'd0, outs_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      run_op(av, bv, model(av, bv), $sformatf("rand%0d", i));
    end

    // Back-to-back: start at k, ignored pulse at k+3, restart in the done cycle.
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    bus.start = 1'b1;
    sb_q.push_back(16'h0008);
    @(posedge clk); #1;
    bus.start = 1'b0;
    prev  = outs_s;
    dones = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          chk("b2b first done cycle", n, 32'd10);
          check_done("b2b first");
          bus.start = 1'b1;
          bus.a     = 8'h64;
          bus.b     = 8'h7F;
          sb_q.push_back(16'h2027);
        end else begin
          chk("b2b second done cycle", n, 32'd21);
          check_done("b2b second");
        end
      end else if (n < 10) begin
        chk("b2b hold", {16'd0, outs_s}, {16'd0, prev});
      end
      if (n == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
      end
    end
    chk("b2b done count", dones, 32'd2);
    chk("b2b scoreboard empty", sb_q.size(), 32'd0);

    // Reset in the middle of an operation.
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset done", {31'd0, bus.done}, 32'd0);
    chk("midreset digits", {16'd0, outs_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    chk("midreset no done", dones, 32'd0);
    run_op(8'hFF, 8'hFF, 16'h2154, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
